// File: rtl/fp_int_norm_if.sv
// Handshake/data bundle for fp_int_norm.
// The master drives the request; the slave (the converter) returns the result and status.
interface fp_int_norm_if;
  logic        start;
  logic [4:0]  exp_set;
  logic [31:0] fixed_point_acc;
  logic [15:0] result;
  logic        done;
  logic        busy;
  logic        ovf;
  logic        uf;

  modport master (output start, exp_set, fixed_point_acc,
                  input  result, done, busy, ovf, uf);
  modport slave  (input  start, exp_set, fixed_point_acc,
                  output result, done, busy, ovf, uf);
endinterface

// File: rtl/fp_int_norm.sv
// fp_int_norm: converts a signed fixed-point accumulator and its block exponent into FP16.
// Normalisation shifts one bit per clock until the MSB is set, then a pack cycle forms the word.
// No subnormals: tiny results flush to zero (uf) and huge results saturate to inf (ovf).
// Build option: define FP_INT_NORM_RNE_EN for round-to-nearest-even; otherwise truncate.
module fp_int_norm #(
  parameter int ACC_WIDTH = 32,
  parameter int FRAC_BITS = 10
) (
  input logic         clk,
  input logic         rst,
  fp_int_norm_if.slave bus
);
  localparam int LZW = $clog2(ACC_WIDTH);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_NORM = 2'd1;
  localparam logic [1:0] S_PACK = 2'd2;

  logic [1:0]           r_state;
  logic                 r_sign;
  logic                 r_zero;
  logic [ACC_WIDTH-1:0] r_mag;
  logic [4:0]           r_exp;
  logic [LZW-1:0]       r_lz;
  logic [15:0]          r_result;
  logic                 r_done;
  logic                 r_ovf;
  logic                 r_uf;

  logic [ACC_WIDTH-1:0] w_abs;
  logic [9:0]           w_mant_t;
  logic [9:0]           w_mant;
  logic                 w_carry;
  logic signed [7:0]    w_e;
  logic signed [7:0]    w_e_rnd;
  logic [15:0]          w_res;
  logic                 w_ovf;
  logic                 w_uf;

  // Magnitude of the input; the most negative value maps onto itself as an unsigned number.
  always_comb begin
    w_abs = bus.fixed_point_acc[ACC_WIDTH-1] ? (~bus.fixed_point_acc + ACC_WIDTH'(1))
                                             : bus.fixed_point_acc;
  end

  // Unbiased position of the leading one folded into the block exponent.
  always_comb begin
    w_mant_t = r_mag[ACC_WIDTH-2 -: 10];
    w_e      = 8'(r_exp) + 8'(ACC_WIDTH-1) - 8'(r_lz) - 8'(FRAC_BITS);
  end

`ifdef FP_INT_NORM_RNE_EN
  logic        w_guard;
  logic        w_sticky;
  logic        w_inc;
  logic [10:0] w_sum;

  // Round to nearest even; an all-ones mantissa rolls over into the exponent.
  always_comb begin
    w_guard  = r_mag[ACC_WIDTH-12];
    w_sticky = |r_mag[ACC_WIDTH-13:0];
    w_inc    = w_guard & (w_sticky | w_mant_t[0]);
    w_sum    = {1'b0, w_mant_t} + {10'd0, w_inc};
    w_mant   = w_sum[9:0];
    w_carry  = w_sum[10];
  end
`else
  // Truncation: bits below the mantissa are dropped.
  always_comb begin
    w_mant  = w_mant_t;
    w_carry = 1'b0;
  end
`endif

  // Classify the rounded value into zero / overflow / underflow / normal.
  always_comb begin
    w_e_rnd = w_e + 8'(w_carry);
    w_res   = {r_sign, w_e_rnd[4:0], w_mant};
    w_ovf   = 1'b0;
    w_uf    = 1'b0;
    if (r_zero) begin
      w_res = 16'h0000;
    end else if (w_e_rnd >= 8'sd31) begin
      w_res = {r_sign, 5'h1F, 10'h000};
      w_ovf = 1'b1;
    end else if (w_e_rnd <= 8'sd0) begin
      w_res = {r_sign, 15'h0000};
      w_uf  = 1'b1;
    end
  end

  // Control FSM: capture in IDLE, shift in NORM, register the packed word in PACK.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_sign   <= 1'b0;
      r_zero   <= 1'b0;
      r_mag    <= '0;
      r_exp    <= '0;
      r_lz     <= '0;
      r_result <= '0;
      r_done   <= 1'b0;
      r_ovf    <= 1'b0;
      r_uf     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_sign  <= bus.fixed_point_acc[ACC_WIDTH-1];
            r_mag   <= w_abs;
            r_exp   <= bus.exp_set;
            r_lz    <= '0;
            r_zero  <= (w_abs == '0);
            r_state <= (w_abs == '0) ? S_PACK : S_NORM;
          end
        end
        S_NORM: begin
          if (!r_mag[ACC_WIDTH-1]) begin
            r_mag <= r_mag << 1;
            r_lz  <= r_lz + LZW'(1);
          end else begin
            r_state <= S_PACK;
          end
        end
        S_PACK: begin
          r_result <= w_res;
          r_ovf    <= w_ovf;
          r_uf     <= w_uf;
          r_done   <= 1'b1;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.result = r_result;
  assign bus.done   = r_done;
  assign bus.ovf    = r_ovf;
  assign bus.uf     = r_uf;
  assign bus.busy   = (r_state != S_IDLE);
endmodule

// File: tb/tb_fp_int_norm.sv
// Bench for fp_int_norm: directed steps plus random traffic, scored through an expectation queue.
module tb_fp_int_norm;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fp_int_norm_if bus();
  fp_int_norm dut (.clk(clk), .rst(rst), .bus(bus.slave));

  typedef struct {
    logic [15:0] res;
    logic        ovf;
    logic        uf;
    int          lat;
    int          acc_cyc;
  } exp_t;

  exp_t q[$];
  exp_t ent;
  int cyc = 0;
  int n_pass = 0;
  int n_tot = 0;
  logic        k_use = 1'b0;
  logic [15:0] k_res = '0;
  logic        k_ovf = 1'b0;
  logic        k_uf = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tot++;
    assert (got === want) n_pass++;
    else $error("FAIL %s: got %h want %h", tag, got, want);
  endtask

  // Independent reference: locate the leading one, slice the mantissa by position.
  function automatic exp_t model(input logic [31:0] acc, input logic [4:0] e);
    exp_t r;
    logic [63:0] mag;
    int p;
    int E;
    logic [9:0] mant;
    logic g;
    logic s;
    logic sign;
    r.acc_cyc = 0;
    if (acc == 32'd0) begin
      r.res = 16'h0000; r.ovf = 1'b0; r.uf = 1'b0; r.lat = 1;
      return r;
    end
    sign = acc[31];
    mag  = sign ? (64'h1_0000_0000 - {32'd0, acc}) : {32'd0, acc};
    p = 31;
    while (!mag[p]) p--;
    E = int'(e) + p - 10;
    if (p >= 10) mant = 10'(mag >> (p - 10));
    else         mant = 10'(mag << (10 - p));
    g = (p >= 11) ? mag[p-11] : 1'b0;
    s = (p >= 12) ? ((mag & ((64'd1 << (p - 11)) - 64'd1)) != 64'd0) : 1'b0;
`ifdef FP_INT_NORM_RNE_EN
    if (g && (s || mant[0])) begin
      if (mant == 10'h3FF) begin mant = 10'h000; E++; end
      else mant = mant + 10'd1;
    end
`else
    if (g && s) mant = mant;
`endif
    r.ovf = 1'b0; r.uf = 1'b0;
    if (E >= 31)      begin r.res = {sign, 5'h1F, 10'h000}; r.ovf = 1'b1; end
    else if (E <= 0)  begin r.res = {sign, 15'h0000};       r.uf  = 1'b1; end
    else                    r.res = {sign, 5'(E), mant};
    r.lat = (31 - p) + 2;
    return r;
  endfunction

  // Scoreboard: pop/compare on done, push on every cycle the DUT will accept a request.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
    end else begin
      if (bus.done) begin
        check("done_expected", 32'(q.size() != 0), 32'd1);
        if (q.size() != 0) begin
          ent = q.pop_front();
          check("result",  32'(bus.result), 32'(ent.res));
          check("ovf",     32'(bus.ovf),    32'(ent.ovf));
          check("uf",      32'(bus.uf),     32'(ent.uf));
          check("latency", 32'(cyc - ent.acc_cyc), 32'(ent.lat));
        end
      end
      if (bus.start && !bus.busy) begin
        ent = model(bus.fixed_point_acc, bus.exp_set);
        if (k_use) begin ent.res = k_res; ent.ovf = k_ovf; ent.uf = k_uf; end
        ent.acc_cyc = cyc + 1;
        q.push_back(ent);
      end
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #1;
      if (!bus.busy && q.size() == 0) break;
    end
    check("drain", 32'(q.size()), 32'd0);
  endtask

  task automatic op(input logic [31:0] acc, input logic [4:0] e, input logic use_k,
                    input logic [15:0] kr, input logic ko, input logic ku);
    @(posedge clk); #1;
    bus.fixed_point_acc = acc; bus.exp_set = e; bus.start = 1'b1;
    k_use = use_k; k_res = kr; k_ovf = ko; k_uf = ku;
    @(posedge clk); #1;
    bus.start = 1'b0; k_use = 1'b0;
    wait_idle();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1);
  end

  initial begin
    bus.start = 1'b0; bus.exp_set = '0; bus.fixed_point_acc = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_result", 32'(bus.result), 32'd0);
    check("rst_done",   32'(bus.done),   32'd0);
    check("rst_busy",   32'(bus.busy),   32'd0);
    check("rst_ovf",    32'(bus.ovf),    32'd0);
    check("rst_uf",     32'(bus.uf),     32'd0);
    @(posedge clk); #1 rst = 1'b0;

    op(32'h0000_0400, 5'd15, 1'b1, 16'h3C00, 1'b0, 1'b0);
    op(32'hFFFF_FC00, 5'd15, 1'b1, 16'hBC00, 1'b0, 1'b0);
    op(32'h0000_0000, 5'd15, 1'b1, 16'h0000, 1'b0, 1'b0);
`ifdef FP_INT_NORM_RNE_EN
    op(32'h0000_0FFF, 5'd15, 1'b1, 16'h4400, 1'b0, 1'b0);
`else
    op(32'h0000_0FFF, 5'd15, 1'b1, 16'h43FF, 1'b0, 1'b0);
`endif
    op(32'h7FFF_FFFF, 5'd30, 1'b1, 16'h7C00, 1'b1, 1'b0);
    op(32'h8000_0000, 5'd30, 1'b1, 16'hFC00, 1'b1, 1'b0);
    op(32'h0000_0001, 5'd0,  1'b1, 16'h0000, 1'b0, 1'b1);

    for (int i = 0; i < 12; i++)
      op($urandom >> $urandom_range(0, 31), 5'($urandom_range(0, 31)), 1'b0, '0, 1'b0, 1'b0);

    // A second start while normalising must be dropped.
    @(posedge clk); #1;
    bus.fixed_point_acc = 32'h0000_0400; bus.exp_set = 5'd15; bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1 bus.start = 1'b1; bus.fixed_point_acc = 32'h1234_5678;
    @(posedge clk); #1 bus.start = 1'b0;
    wait_idle();

    // Start held high with inputs changing every cycle: back-to-back, none lost.
    @(posedge clk); #1 bus.start = 1'b1;
    repeat (80) begin
      bus.fixed_point_acc = $urandom >> $urandom_range(0, 31);
      bus.exp_set = 5'($urandom_range(0, 31));
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    wait_idle();

    // Reset in the middle of normalisation aborts without a done pulse.
    @(posedge clk); #1;
    bus.fixed_point_acc = 32'h0000_0400; bus.exp_set = 5'd15; bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort_result", 32'(bus.result), 32'd0);
    check("abort_busy",   32'(bus.busy),   32'd0);
    check("abort_done",   32'(bus.done),   32'd0);
    check("abort_ovf",    32'(bus.ovf),    32'd0);
    check("abort_uf",     32'(bus.uf),     32'd0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (30) @(posedge clk);
    op(32'h0000_0400, 5'd15, 1'b1, 16'h3C00, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
